// File: rtl/rat_int_pkg.sv
// Shared types and constants for the RAT MCU interrupt controller.
package rat_int_pkg;

  typedef enum logic [1:0] {IDLE, REQ, GAP} int_state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/rat_debounce.sv
// One interrupt channel: synchroniser, optional debounce (RAT_INT_DEBOUNCE_EN), rising-edge pulse.
// Latency: edge pulse 2 cycles after input (3+DB_CYCLES-1 with debounce); no backpressure.
module rat_debounce
  import rat_int_pkg::*;
#(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  if (DB_CYCLES < 2) begin : g_bad_db_cycles
    $error("rat_debounce: DB_CYCLES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync;
  logic                   s2;
  logic                   db;
  logic                   db_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], btn};
    end
  end

  assign s2 = sync[SYNC_STAGES-1];

`ifdef RAT_INT_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DB_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  // Level is accepted on the DB_CYCLES-th consecutive disagreeing cycle, so cnt never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      db  <= 1'b0;
    end else if (s2 == db) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
      cnt <= '0;
      db  <= s2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  always_comb db = s2;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      db_q <= 1'b0;
    end else begin
      db_q <= db;
    end
  end

  assign rise = db & ~db_q;

endmodule

// File: rtl/rat_int_ctrl.sv
// N-channel fixed-priority interrupt controller with mask and one-cycle ACK (debounce via RAT_INT_DEBOUNCE_EN).
// INTERRUPT rises one cycle after an eligible PENDING bit; ACK drops it, then one forced low GAP cycle.
module rat_int_ctrl
  import rat_int_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int DB_CYCLES = 16,
  parameter int ID_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N_CH-1:0] BTN,
  input  logic            MASK_WR,
  input  logic [N_CH-1:0] MASK_IN,
  input  logic            INT_ACK,
  output logic            INTERRUPT,
  output logic [ID_W-1:0] INT_ID,
  output logic [N_CH-1:0] PENDING,
  output logic [N_CH-1:0] MASK
);

  if (N_CH < 1 || N_CH > 16) begin : g_bad_n_ch
    $error("rat_int_ctrl: N_CH must be in 1..16");
  end

  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] eligible;
  logic [N_CH-1:0] pend_clr;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] id_d;
  int_state_t      state_q;
  int_state_t      state_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    rat_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk (CLK),
      .rst (RST),
      .btn (BTN[i]),
      .rise(rise[i])
    );
  end

  assign eligible = PENDING & MASK;

  // Descending scan so the lowest set index is the last assignment and wins.
  always_comb begin
    winner = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    id_d     = INT_ID;
    pend_clr = '0;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d = REQ;
          id_d    = winner;
        end
      end
      REQ: begin
        if (INT_ACK) begin
          state_d = GAP;
          for (int i = 0; i < N_CH; i++) begin
            if (ID_W'(i) == INT_ID) pend_clr[i] = 1'b1;
          end
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A new edge in the same cycle as the ACK re-sets the bit, so the event is not lost.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      INTERRUPT <= 1'b0;
      INT_ID    <= '0;
      PENDING   <= '0;
      MASK      <= '1;
    end else begin
      state_q   <= state_d;
      INTERRUPT <= (state_d == REQ);
      INT_ID    <= id_d;
      PENDING   <= (PENDING & ~pend_clr) | rise;
      if (MASK_WR) MASK <= MASK_IN;
    end
  end

endmodule

// File: tb/tb_rat_int_ctrl.sv
// Scoreboard bench for rat_int_ctrl: each expected request (id, pending, rise edge) is queued by the stimulus
// and checked by a monitor on every INTERRUPT rising edge; direct checks cover static state.
module tb_rat_int_ctrl;

  localparam int N_CH = 4;
  localparam int DB   = 4;
`ifdef RAT_INT_DEBOUNCE_EN
  localparam int LAT = DB + 3;
`else
  localparam int LAT = 3;
`endif

  logic            CLK;
  logic            RST;
  logic [N_CH-1:0] BTN;
  logic            MASK_WR;
  logic [N_CH-1:0] MASK_IN;
  logic            INT_ACK;
  logic            INTERRUPT;
  logic [1:0]      INT_ID;
  logic [N_CH-1:0] PENDING;
  logic [N_CH-1:0] MASK;

  rat_int_ctrl #(
    .N_CH     (N_CH),
    .DB_CYCLES(DB)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .BTN      (BTN),
    .MASK_WR  (MASK_WR),
    .MASK_IN  (MASK_IN),
    .INT_ACK  (INT_ACK),
    .INTERRUPT(INTERRUPT),
    .INT_ID   (INT_ID),
    .PENDING  (PENDING),
    .MASK     (MASK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] id;
    logic [3:0] pend;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input logic [1:0] id, input logic [3:0] pend, input int c);
    exp_t e;
    e.id   = id;
    e.pend = pend;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic ack();
    INT_ACK = 1'b1;
    tick(1);
    INT_ACK = 1'b0;
  endtask

  logic prev_int = 1'b0;
  always @(negedge CLK) begin
    if (INTERRUPT && !prev_int) begin
      if (sb.size() == 0) begin
        chk("unexpected_irq", int'(INTERRUPT), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("irq_id", int'(INT_ID), int'(e.id));
        chk("irq_pending", int'(PENDING), int'(e.pend));
        chk("irq_rise_edge", cyc, e.cyc);
      end
    end
    prev_int = INTERRUPT;
  end

  initial begin
    RST = 1'b1; BTN = '0; MASK_WR = 1'b0; MASK_IN = '0; INT_ACK = 1'b0;
    tick(3);
    chk("rst_int", int'(INTERRUPT), 0);
    chk("rst_id", int'(INT_ID), 0);
    chk("rst_pending", int'(PENDING), 0);
    chk("rst_mask", int'(MASK), 'hF);
    RST = 1'b0;
    tick(2);

`ifdef RAT_INT_DEBOUNCE_EN
    BTN[1] = 1'b1; tick(3); BTN[1] = 1'b0;
    tick(15);
    chk("short_pending", int'(PENDING), 0);
    chk("short_int", int'(INTERRUPT), 0);
`endif

    // Single press on channel 1
    push(2'd1, 4'b0010, cyc + 1 + LAT);
    BTN[1] = 1'b1; tick(12); BTN[1] = 1'b0;
    chk("single_int", int'(INTERRUPT), 1);
    chk("single_id", int'(INT_ID), 1);
    chk("single_pending", int'(PENDING), 'b0010);
    ack();
    chk("single_ack_int", int'(INTERRUPT), 0);
    chk("single_ack_pending", int'(PENDING), 0);
    tick(10);

    // Channels 0 and 2 together: priority, then gap
    push(2'd0, 4'b0101, cyc + 1 + LAT);
    BTN = 4'b0101; tick(LAT + 1);
    chk("pair_first_id", int'(INT_ID), 0);
    push(2'd2, 4'b0100, cyc + 3);
    ack();
    chk("pair_ack_int", int'(INTERRUPT), 0);
    chk("pair_ack_pending", int'(PENDING), 'b0100);
    tick(1);
    chk("pair_gap_int", int'(INTERRUPT), 0);
    tick(1);
    chk("pair_second_int", int'(INTERRUPT), 1);
    chk("pair_second_id", int'(INT_ID), 2);
    BTN = '0;
    ack();
    chk("pair_done_pending", int'(PENDING), 0);
    tick(10);

    // Masked channel still latches; unmask releases it
    MASK_WR = 1'b1; MASK_IN = 4'b1110; tick(1); MASK_WR = 1'b0;
    chk("mask_written", int'(MASK), 'b1110);
    BTN[0] = 1'b1; tick(LAT + 2); BTN[0] = 1'b0;
    chk("masked_pending", int'(PENDING), 'b0001);
    chk("masked_int", int'(INTERRUPT), 0);
    push(2'd0, 4'b0001, cyc + 2);
    MASK_WR = 1'b1; MASK_IN = 4'b1111; tick(1); MASK_WR = 1'b0;
    chk("unmask_mask", int'(MASK), 'hF);
    chk("unmask_int_not_yet", int'(INTERRUPT), 0);
    tick(1);
    chk("unmask_int", int'(INTERRUPT), 1);
    ack();
    chk("unmask_done_pending", int'(PENDING), 0);
    tick(10);

    // New edge on channel 2 coincides with ACK of channel 2: set wins
    push(2'd2, 4'b0100, cyc + 1 + LAT);
    BTN[2] = 1'b1; tick(8); BTN[2] = 1'b0; tick(8);
    chk("setwin_held_int", int'(INTERRUPT), 1);
    chk("setwin_held_id", int'(INT_ID), 2);
    BTN[2] = 1'b1;
    tick(LAT - 1);
    push(2'd2, 4'b0100, cyc + 3);
    ack();
    chk("setwin_pending", int'(PENDING), 'b0100);
    chk("setwin_ack_int", int'(INTERRUPT), 0);
    tick(2);
    chk("setwin_reissue_int", int'(INTERRUPT), 1);
    BTN[2] = 1'b0;
    ack();
    chk("setwin_done_pending", int'(PENDING), 0);
    tick(10);

    // Reset in the middle of a channel 3 request
    push(2'd3, 4'b1000, cyc + 1 + LAT);
    BTN[3] = 1'b1; tick(LAT + 1);
    chk("req3_int", int'(INTERRUPT), 1);
    chk("req3_id", int'(INT_ID), 3);
    MASK_WR = 1'b1; MASK_IN = 4'b0111; tick(1); MASK_WR = 1'b0;
    chk("req3_mask_no_cancel", int'(INTERRUPT), 1);
    chk("req3_mask", int'(MASK), 'b0111);
    RST = 1'b1; BTN = '0; tick(1);
    chk("midrst_int", int'(INTERRUPT), 0);
    chk("midrst_pending", int'(PENDING), 0);
    chk("midrst_mask", int'(MASK), 'hF);
    chk("midrst_id", int'(INT_ID), 0);
    RST = 1'b0;
    repeat (3) begin
      ack();
      tick(1);
    end
    chk("postrst_int", int'(INTERRUPT), 0);
    chk("postrst_pending", int'(PENDING), 0);
    tick(15);

    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rat_int_ctrl.md
# rat_int_ctrl

Parametrised interrupt controller for the RAT MCU wrapper. It replaces the single hard-wired button-to-INTERRUPT path with N channels. Each channel has synchronisation, optional debounce, rising-edge capture into a pending latch, a programmable mask, and fixed priority. It drives the CPU's level INTERRUPT input and identifies the winning channel. The CPU clears the winning channel with a one-cycle acknowledge.

## Interface
Parameters:
- N_CH, 4, number of interrupt channels (1..16)
- DB_CYCLES, 16, consecutive stable cycles required to accept a level change (≥2)
- ID_W, $clog2(N_CH) (min 1), width of INT_ID; derived, do not override

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- BTN  in  N_CH  raw asynchronous button/event inputs, active high
- MASK_WR  in  1  one-cycle strobe; loads MASK from MASK_IN
- MASK_IN  in  N_CH  new mask value, 1 = channel enabled
- INT_ACK  in  1  one-cycle CPU acknowledge of the current request
- INTERRUPT  out  1  registered interrupt request to the CPU
- INT_ID  out  ID_W  index of the channel being requested; valid while INTERRUPT=1
- PENDING  out  N_CH  pending latches, readable by the CPU via an IN port
- MASK  out  N_CH  current mask register

## Operation
- Reset values: INTERRUPT=0, INT_ID=0, PENDING=0, MASK=all ones, FSM=IDLE, synchronisers/debounced levels/counters=0.
- Per channel: 2-flop synchroniser produces s2.
- Debounce (macro on): counter increments while s2 != db; counter clears when s2 == db.
  - When s2 != db for DB_CYCLES consecutive cycles, db takes s2 and the counter clears.
  - Counter width $clog2(DB_CYCLES+1); it never wraps.
- Edge capture: db_q is db delayed one cycle. PENDING[i] is set when db & ~db_q. It stays set until acknowledged or reset.
- Candidates: eligible = PENDING & MASK. The lowest set index wins (fixed priority, channel 0 highest).
- FSM states:
  - IDLE: if eligible != 0, go to REQ; assert INTERRUPT and latch INT_ID = winner.
  - REQ: hold INTERRUPT=1 and INT_ID steady. On INT_ACK, clear PENDING[INT_ID], deassert INTERRUPT, and go to GAP.
    - MASK changes while in REQ do not cancel the request.
  - GAP: exactly one cycle with INTERRUPT=0, then go to IDLE. This guarantees a visible low between back-to-back requests.
- INT_ACK outside REQ is ignored.
- Same-cycle set and clear of one PENDING bit (new edge and INT_ACK together): set wins, so the event stays pending.
- MASK_WR takes effect next cycle. Masked channels still latch PENDING.
- RST at any point, including mid-REQ, returns all state to the reset values on the next edge. No request is remembered.

## Timing
- Cycle 0 is the first rising edge at which BTN[i]=1 is sampled.
- Macro on:
  - db rises at edge 1+DB_CYCLES.
  - PENDING[i] sets at edge 2+DB_CYCLES.
  - INTERRUPT rises at edge 3+DB_CYCLES.
  - With DB_CYCLES=4: INTERRUPT is high after edge 7.
- Macro off:
  - PENDING sets at edge 2.
  - INTERRUPT rises at edge 3.
- INT_ACK sampled at edge k:
  - INTERRUPT=0 and PENDING bit cleared after edge k.
  - Earliest next INTERRUPT rise is after edge k+2.
- A press shorter than DB_CYCLES sampled-stable cycles produces no event.

## Configuration
- RAT_INT_DEBOUNCE_EN defined: debounce counters are instantiated, with behaviour as above.
- RAT_INT_DEBOUNCE_EN undefined: db = s2 directly and no counters exist; DB_CYCLES is ignored. Use this for fast simulation or for clean on-chip event sources.

## Structure
- Package rat_int_pkg:
  - typedef enum logic [1:0] {IDLE, REQ, GAP} int_state_t.
  - Constant SYNC_STAGES = 2.
- Sub-module rat_debounce: one channel with synchroniser, debounce counter, and rising-edge output. It is instantiated N_CH times with a generate loop. The macro is evaluated inside it.

## Test plan
(N_CH=4, DB_CYCLES=4, macro on, 10 ns clock.)
- RST held 3 cycles → INTERRUPT=0, INT_ID=0, PENDING=4'b0000, MASK=4'b1111.
- BTN[1] high 3 cycles then low → PENDING stays 4'b0000 and INTERRUPT never rises.
- BTN[1] held 12 cycles → INTERRUPT=1 and INT_ID=1 after edge 7, PENDING=4'b0010. INT_ACK pulse → INTERRUPT=0 and PENDING=0 the next cycle.
- BTN[0] and BTN[2] rise in the same cycle → INT_ID=0 first. INT_ACK, then one GAP cycle → INTERRUPT=1 with INT_ID=2. Second INT_ACK → PENDING=0.
- MASK_WR with MASK_IN=4'b1110, then press BTN[0] → PENDING=4'b0001, INTERRUPT stays 0. MASK_WR with 4'b1111 → INTERRUPT=1 and INT_ID=0 two cycles later.
- RST asserted while in REQ for channel 3 → next edge gives INTERRUPT=0, PENDING=0, MASK=4'b1111. INT_ACK pulses after reset have no effect.
